// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the shifter arbiter slice.
// Shift op codes and requester identifiers.
package shift_arbiter_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  localparam logic SRC_EX    = 1'b0;
  localparam logic SRC_ALIGN = 1'b1;

endpackage

// File: rtl/shift_arbiter_barrel.sv
// 32-bit log-depth barrel shifter, five 2:1 mux levels.
// Right shifts fill from bit 31 of the original operand for ASR.
module shift_arbiter_barrel
  import shift_arbiter_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  logic [1:0]  op,
  output logic [31:0] result
);

  logic [5:0][31:0] lvl;
  logic             fill;

  assign fill   = (op == SH_ASR) & data[31];
  assign lvl[0] = data;

  for (genvar k = 0; k < 5; k++) begin : g_lvl
    localparam int S = 1 << k;
    assign lvl[k+1] =
      !amount[k]     ? lvl[k] :
      (op == SH_LSL) ? {lvl[k][31-S:0], {S{1'b0}}} :
      (op == SH_ROR) ? {lvl[k][S-1:0], lvl[k][31:S]} :
                       {{S{fill}}, lvl[k][31:S]};
  end

  assign result = lvl[5];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a one-entry registered result stage.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [31:0]      s0_data,
  input  logic [4:0]       s0_amount,
  input  logic [1:0]       s0_op,
  input  logic [TAG_W-1:0] s0_tag,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [31:0]      s1_data,
  input  logic [4:0]       s1_amount,
  input  logic [1:0]       s1_op,
  input  logic [TAG_W-1:0] s1_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_src
);

  logic        rr_ptr;
  logic        grant0;
  logic        grant1;
  logic        can_accept;
  logic        sel;
  logic        xfer;
  logic [31:0] sh_data;
  logic [4:0]  sh_amount;
  logic [1:0]  sh_op;
  logic [31:0] sh_out;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (1'b1)
      s0_valid & !s1_valid: grant0 = 1'b1;
      !s0_valid & s1_valid: grant1 = 1'b1;
      s0_valid & s1_valid: begin
        grant0 = (rr_ptr == SRC_EX);
        grant1 = (rr_ptr == SRC_ALIGN);
      end
      default: ;
    endcase
  end

  // rst gates ready so nothing is taken while the core is held in reset
  assign can_accept = !m_valid | m_ready;
  assign s0_ready   = grant0 & can_accept & !flush & !rst;
  assign s1_ready   = grant1 & can_accept & !flush & !rst;
  assign xfer       = (s0_valid & s0_ready) | (s1_valid & s1_ready);

  assign sel       = grant1 ? SRC_ALIGN : SRC_EX;
  assign sh_data   = sel ? s1_data : s0_data;
  assign sh_amount = sel ? s1_amount : s0_amount;
  assign sh_op     = sel ? s1_op : s0_op;

  shift_arbiter_barrel BarrelShifter (
    .data   (sh_data),
    .amount (sh_amount),
    .op     (sh_op),
    .result (sh_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_tag   <= '0;
      m_src   <= SRC_EX;
      rr_ptr  <= SRC_EX;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= sh_out;
      m_tag   <= sel ? s1_tag : s0_tag;
      m_src   <= sel;
      rr_ptr  <= ~sel;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        s0_valid, s0_ready, s1_valid, s1_ready;
  logic [31:0] s0_data, s1_data;
  logic [4:0]  s0_amount, s1_amount;
  logic [1:0]  s0_op, s1_op;
  logic [3:0]  s0_tag, s1_tag;
  logic        m_valid, m_ready, m_src;
  logic [31:0] m_data;
  logic [3:0]  m_tag;

  int tests = 0;
  int fails = 0;

  bit        mv, ms, rr;
  bit [31:0] md;
  bit [3:0]  mt;
  int        last_w;
  bit        last_acc;

  shift_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
    .s0_amount(s0_amount), .s0_op(s0_op), .s0_tag(s0_tag),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
    .s1_amount(s1_amount), .s1_op(s1_op), .s1_tag(s1_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_tag(m_tag), .m_src(m_src)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_shift(bit [31:0] d, int a, bit [1:0] op);
    case (op)
      2'd0: return d << a;
      2'd1: return d >> a;
      2'd2: return $unsigned($signed(d) >>> a);
      default: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
    endcase
  endfunction

  // One clock: check readies, advance model at the edge, check outputs.
  task automatic step();
    bit can;
    int w;
    #1;
    can = !mv || m_ready;
    w = -1;
    if (!rst && !flush && can) begin
      if (s0_valid && s1_valid) w = rr ? 1 : 0;
      else if (s0_valid) w = 0;
      else if (s1_valid) w = 1;
    end
    chk("s0_ready", {31'b0, s0_ready}, {31'b0, w == 0});
    chk("s1_ready", {31'b0, s1_ready}, {31'b0, w == 1});
    last_acc = s0_ready | s1_ready;
    last_w = w;
    @(posedge clk);
    if (rst) begin
      mv = 0; md = 0; mt = 0; ms = 0; rr = 0;
    end else if (flush) begin
      mv = 0;
    end else if (w == 0) begin
      mv = 1; md = ref_shift(s0_data, s0_amount, s0_op);
      mt = s0_tag; ms = 0; rr = 1;
    end else if (w == 1) begin
      mv = 1; md = ref_shift(s1_data, s1_amount, s1_op);
      mt = s1_tag; ms = 1; rr = 0;
    end else if (m_ready) begin
      mv = 0;
    end
    #1;
    chk("m_valid", {31'b0, m_valid}, {31'b0, mv});
    chk("m_data", m_data, md);
    chk("m_tag", {28'b0, m_tag}, {28'b0, mt});
    chk("m_src", {31'b0, m_src}, {31'b0, ms});
  endtask

  task automatic req0(bit v, bit [31:0] d, bit [4:0] a, bit [1:0] op, bit [3:0] t);
    s0_valid = v; s0_data = d; s0_amount = a; s0_op = op; s0_tag = t;
  endtask

  task automatic req1(bit v, bit [31:0] d, bit [4:0] a, bit [1:0] op, bit [3:0] t);
    s1_valid = v; s1_data = d; s1_amount = a; s1_op = op; s1_tag = t;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    bit [31:0] held;
    rst = 1; flush = 0; m_ready = 1;
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
    chk("rst_mdata", m_data, 32'd0);

    // single requester
    req0(1, 32'h1, 4, 2'b00, 4'h5);
    step();
    req0(0, 0, 0, 0, 0);
    chk("single_data", m_data, 32'h10);
    chk("single_tag", {28'b0, m_tag}, 32'h5);
    chk("single_src", {31'b0, m_src}, 32'd0);
    step();

    // contention alternates from reset
    do_reset();
    req0(1, 32'hF000_0000, 4, 2'b01, 4'h1);
    req1(1, 32'h1234_5678, 8, 2'b11, 4'h2);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("cont_data", m_data, (i % 2) ? 32'h7812_3456 : 32'h0F00_0000);
      chk("cont_src", {31'b0, m_src}, (i % 2));
    end

    // backpressure
    m_ready = 0;
    step();
    held = m_data;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", {31'b0, last_acc}, 32'd0);
      chk("bp_hold", m_data, held);
    end
    m_ready = 1;
    step();
    chk("bp_accept", {31'b0, last_acc}, 32'd1);
    req1(0, 0, 0, 0, 0);

    // ASR corner and amount 0
    req0(1, 32'h8000_0000, 31, 2'b10, 4'h3);
    step();
    chk("asr31", m_data, 32'hFFFF_FFFF);
    for (int op = 0; op < 4; op++) begin
      req0(1, 32'hA5C3_0F1E, 0, op[1:0], 4'h6);
      step();
      chk("amt0", m_data, 32'hA5C3_0F1E);
    end
    req0(0, 0, 0, 0, 0);
    step();

    // flush with s1 pending
    req0(1, 32'h3, 1, 2'b00, 4'h7);
    step();
    req0(0, 0, 0, 0, 0);
    req1(1, 32'h100, 4, 2'b01, 4'h9);
    m_ready = 0; flush = 1;
    step();
    chk("flush_mvalid", {31'b0, m_valid}, 32'd0);
    chk("flush_noacc", {31'b0, last_acc}, 32'd0);
    flush = 0; m_ready = 1;
    step();
    chk("flush_after_src", {31'b0, m_src}, 32'd1);
    chk("flush_after_data", m_data, 32'h10);
    req1(0, 0, 0, 0, 0);

    // reset mid-stream after s0 served (rr would favour s1)
    req0(1, 32'h5, 0, 2'b00, 4'hA);
    step();
    req1(1, 32'h6, 0, 2'b00, 4'hB);
    m_ready = 0;
    rst = 1;
    step();
    rst = 0; m_ready = 1;
    chk("rst_mid_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_mid_tag", {28'b0, m_tag}, 32'd0);
    step();
    chk("rst_first_src", {31'b0, m_src}, 32'd0);
    chk("rst_first_data", m_data, 32'h5);
    req0(0, 0, 0, 0, 0);
    req1(0, 0, 0, 0, 0);

    // randomized traffic
    last_w = -1;
    for (int n = 0; n < 3000; n++) begin
      if (!s0_valid || last_w == 0)
        req0($urandom_range(0, 3) != 0, $urandom,
             ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
             2'($urandom), 4'($urandom));
      if (!s1_valid || last_w == 1)
        req1($urandom_range(0, 3) != 0, $urandom,
             ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom),
             2'($urandom), 4'($urandom));
      m_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 59) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
